// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: width helper and direction encodings.
// Imported by every counter module so direction polarity is defined in one place.
package counter_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // Smallest n with 2**n >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with asynchronous active-high reset to a per-instance value.
// The counter builds its state register from a bank of these cells.
module tff_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic t_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else if (t_i) begin
            q_q <= ~q_q;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mod_n_counter.sv
// Parametrised up/down modulo-N counter with clear, load and cascade outputs.
// State lives in a T-FF bank driven by the XOR of current and next count.
module mod_n_counter
    import counter_pkg::*;
#(
    parameter int MODULUS    = 9,
    parameter int INIT_VALUE = 0,
    localparam int WIDTH     = (clog2(MODULUS) < 1) ? 1 : clog2(MODULUS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if ((MODULUS < 2) || (MODULUS > 65536)) begin : g_bad_modulus
        $error("mod_n_counter: MODULUS must be in 2..65536");
    end
    if ((INIT_VALUE < 0) || (INIT_VALUE >= MODULUS)) begin : g_bad_init
        $error("mod_n_counter: INIT_VALUE must be below MODULUS");
    end

    localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] INIT_CNT = WIDTH'(INIT_VALUE);
    localparam logic [31:0]      MOD_U    = MODULUS;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] toggle;
    logic             loadInRange;
    logic             wrap_q;
    logic             loadErr_q;

    assign loadInRange = ({{(32-WIDTH){1'b0}}, load_val} < MOD_U);

    // Next count; wraps go straight to the far end so MODULUS never appears.
    always_comb begin
        count_d = count_q;
        if (sclr) begin
            count_d = '0;
        end else if (load) begin
            if (loadInRange) begin
                count_d = load_val;
            end
        end else if (en) begin
            if (up_dn == CNT_UP) begin
                count_d = (count_q == MAX_CNT) ? '0 : count_q + 1'b1;
            end else begin
                count_d = (count_q == '0) ? MAX_CNT : count_q - 1'b1;
            end
        end
    end

    assign toggle = count_q ^ count_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_tff
        tff_cell #(
            .RST_VAL (INIT_CNT[i])
        ) u_tff (
            .clk (clk),
            .rst (rst),
            .t_i (toggle[i]),
            .q_o (count_q[i])
        );
    end

    assign tc = en & ~sclr & ~load &
                ((up_dn == CNT_UP) ? (count_q == MAX_CNT) : (count_q == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q    <= 1'b0;
            loadErr_q <= 1'b0;
        end else begin
            wrap_q    <= tc;
            loadErr_q <= ~sclr & load & ~loadInRange;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign load_err = loadErr_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// Self-checking bench for mod_n_counter: directed vector table on a mod-9 instance,
// async-reset sequences on a mod-9 INIT_VALUE=3 instance, and a modulus sweep.
module tb_mod_n_counter;

    typedef struct {
        logic       en;
        logic       upDn;
        logic       sclr;
        logic       load;
        logic [3:0] loadVal;
        logic       expTc;
        logic [3:0] expCount;
        logic       expWrap;
        logic       expLoadErr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, upDn, sclr, load;
    logic [3:0] loadVal4;
    logic [0:0] loadVal1;

    logic [3:0] count9, count9i, count16, count10;
    logic [0:0] count2;
    logic       tc9, tc9i, tc2, tc16, tc10;
    logic       wrap9, wrap9i, wrap2, wrap16, wrap10;
    logic       lerr9, lerr9i, lerr2, lerr16, lerr10;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mod_n_counter #(.MODULUS(9), .INIT_VALUE(0)) dut9 (
        .clk(clk), .rst(rst), .en(en), .up_dn(upDn), .sclr(sclr), .load(load),
        .load_val(loadVal4), .count(count9), .tc(tc9), .wrap(wrap9), .load_err(lerr9));
    mod_n_counter #(.MODULUS(9), .INIT_VALUE(3)) dut9i (
        .clk(clk), .rst(rst), .en(en), .up_dn(upDn), .sclr(sclr), .load(load),
        .load_val(loadVal4), .count(count9i), .tc(tc9i), .wrap(wrap9i), .load_err(lerr9i));
    mod_n_counter #(.MODULUS(2), .INIT_VALUE(0)) dut2 (
        .clk(clk), .rst(rst), .en(en), .up_dn(upDn), .sclr(sclr), .load(load),
        .load_val(loadVal1), .count(count2), .tc(tc2), .wrap(wrap2), .load_err(lerr2));
    mod_n_counter #(.MODULUS(16), .INIT_VALUE(0)) dut16 (
        .clk(clk), .rst(rst), .en(en), .up_dn(upDn), .sclr(sclr), .load(load),
        .load_val(loadVal4), .count(count16), .tc(tc16), .wrap(wrap16), .load_err(lerr16));
    mod_n_counter #(.MODULUS(10), .INIT_VALUE(0)) dut10 (
        .clk(clk), .rst(rst), .en(en), .up_dn(upDn), .sclr(sclr), .load(load),
        .load_val(loadVal4), .count(count10), .tc(tc10), .wrap(wrap10), .load_err(lerr10));

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        en = 1'b0; upDn = 1'b1; sclr = 1'b0; load = 1'b0;
        loadVal4 = 4'd0; loadVal1 = 1'b0;
    endtask

    // Drive one vector at the falling edge, check tc there, then outputs after the rising edge.
    task automatic applyStimulus(input int idx, input vec_t v);
        @(negedge clk);
        en = v.en; upDn = v.upDn; sclr = v.sclr; load = v.load; loadVal4 = v.loadVal;
        #1;
        checkOutput($sformatf("vec%0d tc", idx), int'(tc9), int'(v.expTc));
        @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d count", idx), int'(count9), int'(v.expCount));
        checkOutput($sformatf("vec%0d wrap", idx), int'(wrap9), int'(v.expWrap));
        checkOutput($sformatf("vec%0d load_err", idx), int'(lerr9), int'(v.expLoadErr));
    endtask

    task automatic sweepCheckCount(input string tag, input int m, input logic dir, input int n,
                                   input int cnt, input int wrp);
        int r;
        r = n % m;
        if (dir) begin
            checkOutput($sformatf("%s up n=%0d count", tag, n), cnt, r);
            checkOutput($sformatf("%s up n=%0d wrap", tag, n), wrp, (n > 0 && r == 0) ? 1 : 0);
        end else begin
            checkOutput($sformatf("%s dn n=%0d count", tag, n), cnt, (m - r) % m);
            checkOutput($sformatf("%s dn n=%0d wrap", tag, n), wrp, (r == 1) ? 1 : 0);
        end
    endtask

    task automatic sweepCheckTc(input string tag, input int m, input logic dir, input int n,
                                input int tcv);
        int r;
        r = n % m;
        if (dir) checkOutput($sformatf("%s up n=%0d tc", tag, n), tcv, (r == m - 1) ? 1 : 0);
        else     checkOutput($sformatf("%s dn n=%0d tc", tag, n), tcv, (r == 0) ? 1 : 0);
    endtask

    task automatic runSweep(input logic dir, input int edges);
        @(negedge clk);
        idleInputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        upDn = dir;
        for (int n = 0; n < edges; n++) begin
            #1;
            sweepCheckTc("m2", 2, dir, n, int'(tc2));
            sweepCheckTc("m16", 16, dir, n, int'(tc16));
            sweepCheckTc("m10", 10, dir, n, int'(tc10));
            @(posedge clk);
            #1;
            sweepCheckCount("m2", 2, dir, n + 1, int'(count2), int'(wrap2));
            sweepCheckCount("m16", 16, dir, n + 1, int'(count16), int'(wrap16));
            sweepCheckCount("m10", 10, dir, n + 1, int'(count10), int'(wrap10));
            @(negedge clk);
        end
    endtask

    task automatic addVec(input logic e, input logic u, input logic s, input logic l,
                          input logic [3:0] lv, input logic t, input logic [3:0] c,
                          input logic w, input logic le);
        vec_t v;
        v.en = e; v.upDn = u; v.sclr = s; v.load = l; v.loadVal = lv;
        v.expTc = t; v.expCount = c; v.expWrap = w; v.expLoadErr = le;
        vecs.push_back(v);
    endtask

    initial begin
        // Count up from reset: 1..8, wrap to 0, then 1.
        for (int k = 1; k <= 8; k++) addVec(1, 1, 0, 0, 4'd0, 0, 4'(k), 0, 0);
        addVec(1, 1, 0, 0, 4'd0,  1, 4'd0, 1, 0);
        addVec(1, 1, 0, 0, 4'd0,  0, 4'd1, 0, 0);
        // Count down through the 0 -> 8 wrap.
        addVec(1, 0, 0, 0, 4'd0,  0, 4'd0, 0, 0);
        addVec(1, 0, 0, 0, 4'd0,  1, 4'd8, 1, 0);
        addVec(1, 0, 0, 0, 4'd0,  0, 4'd7, 0, 0);
        // Loads: good, out of range, load beats en.
        addVec(0, 0, 0, 1, 4'd5,  0, 4'd5, 0, 0);
        addVec(0, 0, 0, 1, 4'd12, 0, 4'd5, 0, 1);
        addVec(1, 1, 0, 1, 4'd2,  0, 4'd2, 0, 0);
        addVec(1, 1, 0, 1, 4'd8,  0, 4'd8, 0, 0);
        addVec(1, 1, 0, 0, 4'd0,  1, 4'd0, 1, 0);
        addVec(0, 1, 0, 1, 4'd9,  0, 4'd0, 0, 1);
        // Priority: sclr over load and en, then hold with en low.
        addVec(1, 1, 0, 1, 4'd4,  0, 4'd4, 0, 0);
        addVec(1, 1, 1, 1, 4'd7,  0, 4'd0, 0, 0);
        addVec(0, 1, 0, 1, 4'd4,  0, 4'd4, 0, 0);
        for (int k = 0; k < 3; k++) addVec(0, 1, 0, 0, 4'd0, 0, 4'd4, 0, 0);
        addVec(1, 1, 0, 1, 4'd8,  0, 4'd8, 0, 0);
        addVec(1, 1, 1, 1, 4'd12, 0, 4'd0, 0, 0);
        addVec(0, 0, 0, 0, 4'd0,  0, 4'd0, 0, 0);
        addVec(1, 0, 0, 1, 4'd15, 0, 4'd0, 0, 1);
        addVec(1, 0, 0, 0, 4'd0,  1, 4'd8, 1, 0);

        idleInputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset count9", int'(count9), 0);
        checkOutput("reset count9i", int'(count9i), 3);
        checkOutput("reset wrap9", int'(wrap9), 0);
        checkOutput("reset load_err9", int'(lerr9), 0);
        checkOutput("reset tc9", int'(tc9), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

        // Async reset while load_err is high.
        @(negedge clk);
        idleInputs(); load = 1'b1; loadVal4 = 4'd6;
        @(posedge clk); #1;
        checkOutput("async load6 count9i", int'(count9i), 6);
        @(negedge clk);
        loadVal4 = 4'd12;
        @(posedge clk); #1;
        checkOutput("async bad load count9i", int'(count9i), 6);
        checkOutput("async bad load load_err9i", int'(lerr9i), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst count9i", int'(count9i), 3);
        checkOutput("async rst load_err9i", int'(lerr9i), 0);
        checkOutput("async rst count9", int'(count9), 0);

        // Async reset while wrap is high.
        @(negedge clk);
        rst = 1'b0; load = 1'b1; loadVal4 = 4'd8;
        @(posedge clk); #1;
        checkOutput("async load8 count9i", int'(count9i), 8);
        @(negedge clk);
        load = 1'b0; en = 1'b1; upDn = 1'b1;
        @(posedge clk); #1;
        checkOutput("async wrap count9i", int'(count9i), 0);
        checkOutput("async wrap wrap9i", int'(wrap9i), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst2 count9i", int'(count9i), 3);
        checkOutput("async rst2 wrap9i", int'(wrap9i), 0);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        checkOutput("release hold count9i", int'(count9i), 3);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        checkOutput("first count count9i", int'(count9i), 4);

        runSweep(1'b1, 40);
        runSweep(1'b0, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
